// File: rtl/dsp_cfg_pkg.sv
// Shared types and constants for the DSP column frame loader.
// State encoding, column geometry defaults and the frame-strobe decoder.
// No logic state lives here; consumers import with dsp_cfg_pkg::*.
package dsp_cfg_pkg;

    localparam int DSP_NUM_ROWS       = 2;
    localparam int DSP_FRAMES_PER_COL = 20;
    localparam int DSP_FRAME_BITS     = 32;
    localparam int DSP_FRAME_IDX_W    = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        HOLD,
        DONE
    } state_t;

    function automatic logic [DSP_FRAMES_PER_COL-1:0] onehot_strobe(
        input logic [DSP_FRAME_IDX_W-1:0] idx
    );
        logic [DSP_FRAMES_PER_COL-1:0] v;
        v = '0;
        for (int i = 0; i < DSP_FRAMES_PER_COL; i++) begin
            if (idx == DSP_FRAME_IDX_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/dsp_frame_row_buf.sv
// Row register bank holding one assembled frame (one word per tile row).
// Latency: write visible on rows_dat one cycle after wr_en; clr wins over wr_en.
// Backpressure: none, the bank accepts a write every cycle it is enabled.
module dsp_frame_row_buf #(
    parameter int NumRows         = 2,
    parameter int FrameBitsPerRow = 32,
    parameter int RowIdxW         = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [RowIdxW-1:0]                 wr_row,
    input  logic [FrameBitsPerRow-1:0]         wr_dat,
    input  logic                               clr,
    output logic [NumRows*FrameBitsPerRow-1:0] rows_dat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_dat <= '0;
        end else if (clr) begin
            rows_dat <= '0;
        end else if (wr_en) begin
            for (int r = 0; r < NumRows; r++) begin
                if (wr_row == RowIdxW'(r)) begin
                    rows_dat[r*FrameBitsPerRow +: FrameBitsPerRow] <= wr_dat;
                end
            end
        end
    end

endmodule

// File: rtl/dsp_frame_loader.sv
// Streams config words into per-row FrameData, then fires the one-hot FrameStrobe per frame.
// Latency: NumRows+2 cycles per frame with continuous input; done one cycle after the last HOLD.
// Backpressure: in_ready only in LOAD; stalls indefinitely while in_valid is low.
module dsp_frame_loader
    import dsp_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = DSP_FRAMES_PER_COL,
    parameter int FrameBitsPerRow = DSP_FRAME_BITS,
    parameter int NumRows         = DSP_NUM_ROWS,
    parameter int FrameIdxW       = DSP_FRAME_IDX_W
) (
    input  logic                               UserCLK,
    input  logic                               resetn,
    input  logic                               start,
    input  logic [FrameIdxW-1:0]               num_frames,
    input  logic                               abort,
    input  logic [FrameBitsPerRow-1:0]         in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    localparam int RowIdxW = (NumRows > 1) ? $clog2(NumRows) : 1;

    state_t               state;
    logic [FrameIdxW-1:0] frame_idx;
    logic [FrameIdxW-1:0] num_lat;
    logic [RowIdxW-1:0]   row_idx;

    logic accept;
    logic last_row;
    logic last_frame;
    logic do_abort;
    logic row_clr;

    assign in_ready   = (state == LOAD);
    assign accept     = in_ready && in_valid;
    assign last_row   = (row_idx == RowIdxW'(NumRows - 1));
    assign last_frame = (frame_idx == (num_lat - FrameIdxW'(1)));
    assign do_abort   = abort && (state != IDLE);
    // Frame data is wiped on abort and as the sequence enters DONE.
    assign row_clr    = do_abort || ((state == HOLD) && last_frame);

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            frame_idx   <= '0;
            num_lat     <= '0;
            row_idx     <= '0;
            FrameStrobe <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (do_abort) begin
                state       <= IDLE;
                frame_idx   <= '0;
                row_idx     <= '0;
                FrameStrobe <= '0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            if ((num_frames == '0) ||
                                (num_frames > FrameIdxW'(MaxFramesPerCol))) begin
                                error <= 1'b1;
                            end else begin
                                num_lat   <= num_frames;
                                frame_idx <= '0;
                                row_idx   <= '0;
                                busy      <= 1'b1;
                                state     <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            if (last_row) begin
                                FrameStrobe <= MaxFramesPerCol'(
                                    onehot_strobe(DSP_FRAME_IDX_W'(frame_idx)));
                                state       <= STROBE;
                            end else begin
                                row_idx <= row_idx + RowIdxW'(1);
                            end
                        end
                    end
                    STROBE: begin
                        FrameStrobe <= '0;
                        state       <= HOLD;
                    end
                    HOLD: begin
                        row_idx <= '0;
                        if (last_frame) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            frame_idx <= frame_idx + FrameIdxW'(1);
                            state     <= LOAD;
                        end
                    end
                    DONE: begin
                        frame_idx <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    dsp_frame_row_buf #(
        .NumRows        (NumRows),
        .FrameBitsPerRow(FrameBitsPerRow),
        .RowIdxW        (RowIdxW)
    ) u_row_buf (
        .clk     (UserCLK),
        .rst_n   (resetn),
        .wr_en   (accept),
        .wr_row  (row_idx),
        .wr_dat  (in_data),
        .clr     (row_clr),
        .rows_dat(FrameData)
    );

endmodule

// File: doc/dsp_frame_loader.md
Name: dsp_frame_loader

Overview:
Configuration sequencer for one DSP supertile column (top and bottom tiles). It accepts a valid/ready stream of 32-bit configuration words and assembles one word per tile row into a frame. It drives the per-row FrameData buses, then fires the one-hot FrameStrobe for that frame index. It sits between the fabric configuration port and the supertile's FrameData/FrameStrobe inputs, replacing the global frame-select path for a standalone DSP column.

Parameters:
MaxFramesPerCol, 20, number of frames per column; FrameStrobe width.
FrameBitsPerRow, 32, bits per row per frame; input word width.
NumRows, 2, tile rows in the supertile; row 0 is the top tile (Y0).
FrameIdxW, 5, width of the frame index/count; must satisfy 2^FrameIdxW > MaxFramesPerCol.

Ports:
UserCLK  in  1  clock.
resetn  in  1  asynchronous active-low reset.
start  in  1  begin a load; sampled only in IDLE.
num_frames  in  FrameIdxW  frames to write, starting at index 0; legal range 1..MaxFramesPerCol.
abort  in  1  terminate the sequence; returns to IDLE.
in_data  in  FrameBitsPerRow  configuration word.
in_valid  in  1  in_data is valid.
in_ready  out  1  loader accepts a word this cycle.
FrameData  out  NumRows*FrameBitsPerRow  row r at [r*FrameBitsPerRow +: FrameBitsPerRow].
FrameStrobe  out  MaxFramesPerCol  one-hot frame write strobe.
busy  out  1  state is not IDLE.
done  out  1  one-cycle pulse when all frames are written.
error  out  1  one-cycle pulse on an illegal num_frames at start.

Behaviour:
- Reset (async assert, sync-deasserted use): state=IDLE. All outputs are 0, including the FrameData registers and the frame_idx/row_idx counters.
- All outputs are registered except in_ready, which is decoded from state (state==LOAD).
- States: IDLE, LOAD, STROBE, HOLD, DONE.
- IDLE + start:
  - num_frames==0 or num_frames>MaxFramesPerCol: pulse error next cycle, stay IDLE.
  - Otherwise: latch num_frames, set frame_idx=0 and row_idx=0, go to LOAD.
- LOAD:
  - in_ready=1. On in_valid&in_ready, row register[row_idx] <= in_data.
  - If row_idx==NumRows-1, go to STROBE; otherwise row_idx++.
  - If in_valid is low, stall indefinitely with no timeout.
- STROBE (one cycle): FrameStrobe = 1<<frame_idx. FrameData is stable and equals the assembled rows. in_ready=0.
- HOLD (one cycle): FrameStrobe=0 and FrameData is held, giving data hold past the strobe falling edge.
  - If frame_idx==latched_num_frames-1, go to DONE.
  - Otherwise frame_idx++, row_idx=0, go to LOAD.
- DONE (one cycle): done=1, FrameData cleared to 0, go to IDLE.
- Timing with continuous in_valid, start sampled at cycle 0:
  - LOAD occupies cycles 1..NumRows.
  - Strobe is high at cycle NumRows+1; HOLD is at NumRows+2.
  - Each frame costs NumRows+2 cycles.
  - done is high at cycle num_frames*(NumRows+2)+1.
- FrameStrobe is never high while FrameData is changing, and at most one bit is ever set.
- abort (any non-IDLE state, highest priority):
  - Next state is IDLE; FrameStrobe, FrameData and the counters clear next cycle. No done pulse.
  - abort in IDLE has no effect.
  - abort and start in the same cycle: abort wins, start is ignored.
- start while busy is ignored; num_frames is not re-sampled.
- Async reset mid-sequence clears everything immediately. A partially written frame is never strobed.

Decomposition:
- Shared package dsp_cfg_pkg holds:
  - the state enum (IDLE, LOAD, STROBE, HOLD, DONE);
  - the constants DSP_NUM_ROWS=2, DSP_FRAMES_PER_COL=20, DSP_FRAME_BITS=32;
  - a function onehot_strobe(idx) returning a MaxFramesPerCol-wide one-hot vector.
- One natural sub-module, dsp_frame_row_buf: the NumRows x FrameBitsPerRow row register bank. It has a write enable, a row index, a synchronous clear and the flat output.
- The FSM and counters stay in the top module.

Test Plan:
- Reset/idle: hold resetn=0 then release; no start -> all outputs 0, in_ready=0, busy=0 for 10 cycles.
- Single frame: start, num_frames=1, words 0xAAAA0001 then 0xBBBB0002, both valid continuously -> FrameData=0xBBBB0002_AAAA0001 and FrameStrobe=20'h00001 at cycle 3 only, done at cycle 5.
- Full column with backpressure: num_frames=20, in_valid toggled 50% randomly, words = frame*2+row -> FrameStrobe bit k fires exactly once, in order 0..19. Row 0 holds 2k and row 1 holds 2k+1 at each strobe; exactly one done pulse.
- Illegal count: start with num_frames=0, then with 21 -> error pulse each time, busy stays 0, no strobe.
- Abort mid-frame: num_frames=3, assert abort after the first word of frame 1 -> next cycle IDLE, FrameData=0, no strobe bit 1, no done. A fresh start then completes normally.
- Simultaneous/ignored events: start together with abort from IDLE -> stays IDLE. start asserted during LOAD -> ignored and the original num_frames is honoured. Async resetn pulse during STROBE -> FrameStrobe drops to 0 immediately.
